// File: rtl/countdown_pkg.sv
// countdown_pkg
//   Shared definitions for the countdown timer slice.
//   - state_t : FSM encoding (ST_IDLE = 0, ST_RUN = 1)
//   - DIV_MIN / DIV_MAX : legal prescaler ratio range
package countdown_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam int DIV_MIN = 1;
   localparam int DIV_MAX = 256;

endpackage

// File: rtl/tick_divider.sv
// tick_divider
//   Prescaler for the countdown timer. While en is high it counts
//   0..DIV-1 and wraps; tick is high during the cycle in which the
//   count sits at DIV-1, so the next clock edge is a count step.
//   With DIV = 1 there is nothing to count and tick simply follows en.
// Ports:
//   clk  - clock, all state updates on posedge
//   rst  - synchronous active-high reset, clears the prescaler
//   clr  - synchronous clear, restarts the prescaler from 0
//   en   - count enable (timer is running)
//   tick - high when the next edge is a count step
module tick_divider
   import countdown_pkg::*;
#(
   parameter int DIV = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tick
);

   // An out-of-range ratio is pulled back into the legal window so the
   // counter width below always stays between 1 and 8 bits.
   localparam int DIV_EFF = (DIV < DIV_MIN) ? DIV_MIN :
                            (DIV > DIV_MAX) ? DIV_MAX : DIV;
   localparam int CW      = (DIV_EFF > 1) ? $clog2(DIV_EFF) : 1;

   generate
      if (DIV_EFF == 1) begin : gNoDiv
         // Every running cycle is a step, so no counter is needed and the
         // clock/reset/clear inputs have nothing to act on.
         logic unusedInputs;
         assign unusedInputs = &{1'b0, clk, rst, clr};
         assign tick = en;
      end else begin : gDiv
         logic [CW-1:0] count;

         // Free-running modulo-DIV counter that only advances while the
         // timer runs. clr restarts the interval so that a fresh load
         // always gets a full DIV cycles before its first step.
         always_ff @(posedge clk) begin
            if (rst || clr) begin
               count <= '0;
            end else if (en) begin
               if (count == CW'(DIV_EFF - 1)) begin
                  count <= '0;
               end else begin
                  count <= count + 1'b1;
               end
            end
         end

         assign tick = en && (count == CW'(DIV_EFF - 1));
      end
   endgenerate

endmodule

// File: rtl/countdown_timer.sv
// countdown_timer
//   Loadable down-counter with prescaler, start/stop control, optional
//   auto-reload and a one-cycle terminal-count pulse.
// Ports:
//   clk         - clock, all state updates on posedge
//   rst         - synchronous active-high reset
//   load_val    - value loaded on start or auto-reload
//   start       - one-cycle request: load load_val and run
//   stop        - one-cycle request: abort, hold current count
//   auto_reload - at terminal count: reload and keep running
//   q           - current count (registered)
//   busy        - high while running (registered)
//   done        - one-cycle terminal-count pulse (registered)
module countdown_timer
   import countdown_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int DIV   = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] load_val,
   input  logic             start,
   input  logic             stop,
   input  logic             auto_reload,
   output logic [WIDTH-1:0] q,
   output logic             busy,
   output logic             done
);

   state_t state;
   logic   tick;

   // The prescaler is cleared by any start or stop request. In IDLE the
   // prescaler is already at 0, so clearing there is harmless; in RUN it
   // gives a restart a full first interval and leaves a stopped timer
   // ready for the next start.
   tick_divider #(
      .DIV (DIV)
   ) uDivider (
      .clk  (clk),
      .rst  (rst),
      .clr  (start | stop),
      .en   (state == ST_RUN),
      .tick (tick)
   );

   // Main FSM with the count, busy and done registers. Priority inside
   // RUN is stop, then start (restart), then a prescaler tick, so a tick
   // landing on the same edge as stop or start is discarded. Terminal
   // count is detected as a tick while q is already 0, which is what
   // gives N+1 steps for a load value of N and keeps q from wrapping.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         q     <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start && !stop) begin
                  q     <= load_val;
                  busy  <= 1'b1;
                  state <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (stop) begin
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end else if (start) begin
                  q <= load_val;
               end else if (tick) begin
                  if (q != '0) begin
                     q <= q - 1'b1;
                  end else begin
                     done <= 1'b1;
                     if (auto_reload) begin
                        q <= load_val;
                     end else begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                     end
                  end
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer
//   Scoreboard bench for countdown_timer. Two instances are exercised:
//   dut1 with DIV = 1 and dut4 with DIV = 4 (both WIDTH = 4). Stimulus
//   pushes the hand-computed q/busy/done expected after a given clock
//   edge, plus the edges on which done must pulse; a separate monitor
//   compares at each falling edge and flags any done nobody asked for.
module tb_countdown_timer;

   typedef struct {
      int         dut;
      int         cyc;
      logic [3:0] q;
      logic       busy;
      logic       done;
      string      tag;
   } exp_t;

   logic       clk;
   logic       rst;
   logic [3:0] lv1, lv4;
   logic       start1, stop1, ar1;
   logic       start4, stop4, ar4;
   logic [3:0] q1, q4;
   logic       busy1, busy4, done1, done4;

   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t expQ[$];
   int   doneQ1[$];
   int   doneQ4[$];

   countdown_timer #(.WIDTH(4), .DIV(1)) dut1 (
      .clk(clk), .rst(rst), .load_val(lv1), .start(start1), .stop(stop1),
      .auto_reload(ar1), .q(q1), .busy(busy1), .done(done1)
   );

   countdown_timer #(.WIDTH(4), .DIV(4)) dut4 (
      .clk(clk), .rst(rst), .load_val(lv4), .start(start4), .stop(stop4),
      .auto_reload(ar4), .q(q4), .busy(busy4), .done(done4)
   );

   // 10-time-unit clock; the first rising edge is edge number 1.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Edge counter: at the falling edge after rising edge k, cyc == k.
   always @(posedge clk) cyc <= cyc + 1;

   // Record the expected outputs seen just after rising edge c.
   function automatic void expectAt(input int d, input int c, input logic [3:0] eq,
                                    input logic eb, input logic ed, input string tag);
      exp_t e;
      e.dut  = d;
      e.cyc  = c;
      e.q    = eq;
      e.busy = eb;
      e.done = ed;
      e.tag  = tag;
      expQ.push_back(e);
   endfunction

   // Compare one scoreboard entry against the selected instance.
   task automatic checkOutput(input exp_t e);
      logic [3:0] aq;
      logic       ab, ad;
      aq = (e.dut == 1) ? q1    : q4;
      ab = (e.dut == 1) ? busy1 : busy4;
      ad = (e.dut == 1) ? done1 : done4;
      checks++;
      if (aq !== e.q || ab !== e.busy || ad !== e.done) begin
         errors++;
         $display("[TB] FAIL %s dut%0d edge %0d: got q=%0d busy=%b done=%b, want q=%0d busy=%b done=%b",
                  e.tag, e.dut, e.cyc, aq, ab, ad, e.q, e.busy, e.done);
      end
   endtask

   // Drive one set of requests for the chosen instance; the caller is at
   // a falling edge, so the values are sampled on edge cyc+1.
   task automatic applyStimulus(input int d, input logic st, input logic sp,
                                input logic ar, input logic [3:0] lv, output int edgeNo);
      if (d == 1) begin
         start1 = st; stop1 = sp; ar1 = ar; lv1 = lv;
      end else begin
         start4 = st; stop4 = sp; ar4 = ar; lv4 = lv;
      end
      edgeNo = cyc + 1;
   endtask

   // Advance n falling edges, dropping single-cycle requests after one edge.
   task automatic waitCycles(input int n);
      repeat (n) begin
         @(negedge clk);
         start1 = 1'b0; stop1 = 1'b0;
         start4 = 1'b0; stop4 = 1'b0;
      end
   endtask

   // Monitor: consume every scoreboard entry due this cycle and match
   // each observed done pulse against the list of expected pulse edges.
   always @(negedge clk) begin
      for (int i = expQ.size() - 1; i >= 0; i--) begin
         if (expQ[i].cyc == cyc) begin
            checkOutput(expQ[i]);
            expQ.delete(i);
         end
      end
      if (done1 === 1'b1) begin
         int hit1;
         hit1 = -1;
         checks++;
         foreach (doneQ1[i]) if (doneQ1[i] == cyc) hit1 = i;
         if (hit1 >= 0) doneQ1.delete(hit1);
         else begin
            errors++;
            $display("[TB] FAIL unexpected_done dut1 edge %0d: got done=1, want done=0", cyc);
         end
      end
      if (done4 === 1'b1) begin
         int hit4;
         hit4 = -1;
         checks++;
         foreach (doneQ4[i]) if (doneQ4[i] == cyc) hit4 = i;
         if (hit4 >= 0) doneQ4.delete(hit4);
         else begin
            errors++;
            $display("[TB] FAIL unexpected_done dut4 edge %0d: got done=1, want done=0", cyc);
         end
      end
   end

   // Safety net in case the sequence ever stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int e;
      rst = 1'b1;
      lv1 = 4'd0; start1 = 1'b0; stop1 = 1'b0; ar1 = 1'b0;
      lv4 = 4'd0; start4 = 1'b0; stop4 = 1'b0; ar4 = 1'b0;

      // Reset state of both instances
      expectAt(1, 2, 4'd0, 1'b0, 1'b0, "reset_state");
      expectAt(4, 2, 4'd0, 1'b0, 1'b0, "reset_state");
      waitCycles(2);
      rst = 1'b0;
      waitCycles(1);

      // Basic count, DIV=1, load 3: 3,2,1,0 then done 4 edges after start
      applyStimulus(1, 1'b1, 1'b0, 1'b0, 4'd3, e);
      expectAt(1, e,     4'd3, 1'b1, 1'b0, "basic_load");
      expectAt(1, e + 1, 4'd2, 1'b1, 1'b0, "basic_q2");
      expectAt(1, e + 2, 4'd1, 1'b1, 1'b0, "basic_q1");
      expectAt(1, e + 3, 4'd0, 1'b1, 1'b0, "basic_q0");
      expectAt(1, e + 4, 4'd0, 1'b0, 1'b1, "basic_done");
      expectAt(1, e + 5, 4'd0, 1'b0, 1'b0, "basic_after");
      doneQ1.push_back(e + 4);
      waitCycles(6);

      // Prescaler, DIV=4, load 2: each value held 4 cycles, done at +12
      applyStimulus(4, 1'b1, 1'b0, 1'b0, 4'd2, e);
      expectAt(4, e,      4'd2, 1'b1, 1'b0, "presc_load");
      expectAt(4, e + 3,  4'd2, 1'b1, 1'b0, "presc_hold2");
      expectAt(4, e + 4,  4'd1, 1'b1, 1'b0, "presc_q1");
      expectAt(4, e + 7,  4'd1, 1'b1, 1'b0, "presc_hold1");
      expectAt(4, e + 8,  4'd0, 1'b1, 1'b0, "presc_q0");
      expectAt(4, e + 11, 4'd0, 1'b1, 1'b0, "presc_hold0");
      expectAt(4, e + 12, 4'd0, 1'b0, 1'b1, "presc_done");
      expectAt(4, e + 13, 4'd0, 1'b0, 1'b0, "presc_after");
      doneQ4.push_back(e + 12);
      waitCycles(14);

      // Auto-reload, DIV=1, load 2: done every 3 edges, busy stays high
      applyStimulus(1, 1'b1, 1'b0, 1'b1, 4'd2, e);
      for (int k = 0; k < 10; k++) begin
         expectAt(1, e + k, 4'(2 - (k % 3)), 1'b1, (k > 0) && (k % 3 == 0), "reload_run");
         if (k > 0 && k % 3 == 0) doneQ1.push_back(e + k);
      end
      waitCycles(10);
      ar1 = 1'b0;
      expectAt(1, e + 10, 4'd1, 1'b1, 1'b0, "reload_drop_q1");
      expectAt(1, e + 11, 4'd0, 1'b1, 1'b0, "reload_drop_q0");
      expectAt(1, e + 12, 4'd0, 1'b0, 1'b1, "reload_drop_done");
      expectAt(1, e + 13, 4'd0, 1'b0, 1'b0, "reload_drop_idle");
      doneQ1.push_back(e + 12);
      waitCycles(4);

      // Stop while q=5: count frozen, busy low, no done
      applyStimulus(1, 1'b1, 1'b0, 1'b0, 4'd7, e);
      expectAt(1, e,     4'd7, 1'b1, 1'b0, "stop_load");
      expectAt(1, e + 2, 4'd5, 1'b1, 1'b0, "stop_q5");
      waitCycles(3);
      applyStimulus(1, 1'b0, 1'b1, 1'b0, 4'd7, e);
      expectAt(1, e,     4'd5, 1'b0, 1'b0, "stop_hold");
      expectAt(1, e + 2, 4'd5, 1'b0, 1'b0, "stop_hold_later");
      waitCycles(3);

      // start+stop together in RUN: stop wins, q held
      applyStimulus(1, 1'b1, 1'b0, 1'b0, 4'd4, e);
      expectAt(1, e + 1, 4'd3, 1'b1, 1'b0, "both_pre");
      waitCycles(2);
      applyStimulus(1, 1'b1, 1'b1, 1'b0, 4'd9, e);
      expectAt(1, e,     4'd3, 1'b0, 1'b0, "both_run_stop");
      expectAt(1, e + 1, 4'd3, 1'b0, 1'b0, "both_run_idle");
      waitCycles(2);

      // start+stop together in IDLE: nothing happens
      applyStimulus(1, 1'b1, 1'b1, 1'b0, 4'd12, e);
      expectAt(1, e,     4'd3, 1'b0, 1'b0, "both_idle");
      expectAt(1, e + 1, 4'd3, 1'b0, 1'b0, "both_idle_later");
      waitCycles(2);

      // Restart during RUN at q=1: reload to 6, no done, then full period
      applyStimulus(1, 1'b1, 1'b0, 1'b0, 4'd3, e);
      expectAt(1, e + 2, 4'd1, 1'b1, 1'b0, "restart_q1");
      waitCycles(3);
      applyStimulus(1, 1'b1, 1'b0, 1'b0, 4'd6, e);
      expectAt(1, e,     4'd6, 1'b1, 1'b0, "restart_reload");
      expectAt(1, e + 1, 4'd5, 1'b1, 1'b0, "restart_q5");
      expectAt(1, e + 6, 4'd0, 1'b1, 1'b0, "restart_q0");
      expectAt(1, e + 7, 4'd0, 1'b0, 1'b1, "restart_done");
      doneQ1.push_back(e + 7);
      waitCycles(9);

      // load_val=0: done on the first tick (DIV=1 and DIV=4)
      applyStimulus(1, 1'b1, 1'b0, 1'b0, 4'd0, e);
      expectAt(1, e,     4'd0, 1'b1, 1'b0, "zero1_load");
      expectAt(1, e + 1, 4'd0, 1'b0, 1'b1, "zero1_done");
      expectAt(1, e + 2, 4'd0, 1'b0, 1'b0, "zero1_after");
      doneQ1.push_back(e + 1);
      waitCycles(3);
      applyStimulus(4, 1'b1, 1'b0, 1'b0, 4'd0, e);
      expectAt(4, e,     4'd0, 1'b1, 1'b0, "zero4_load");
      expectAt(4, e + 3, 4'd0, 1'b1, 1'b0, "zero4_wait");
      expectAt(4, e + 4, 4'd0, 1'b0, 1'b1, "zero4_done");
      doneQ4.push_back(e + 4);
      waitCycles(5);

      // load_val=15: 16 ticks to terminal, no wrap; load_val change ignored
      applyStimulus(1, 1'b1, 1'b0, 1'b0, 4'd15, e);
      for (int k = 0; k < 16; k++) begin
         expectAt(1, e + k, 4'(15 - k), 1'b1, 1'b0, "max_count");
      end
      expectAt(1, e + 16, 4'd0, 1'b0, 1'b1, "max_done");
      expectAt(1, e + 17, 4'd0, 1'b0, 1'b0, "max_no_wrap");
      doneQ1.push_back(e + 16);
      waitCycles(1);
      lv1 = 4'd5;
      waitCycles(17);

      // Reset for 2 cycles mid-run at q=7, no done afterwards
      applyStimulus(1, 1'b1, 1'b0, 1'b0, 4'd9, e);
      expectAt(1, e + 2, 4'd7, 1'b1, 1'b0, "rst_pre_q7");
      expectAt(1, e + 3, 4'd0, 1'b0, 1'b0, "rst_mid_run");
      expectAt(4, e + 3, 4'd0, 1'b0, 1'b0, "rst_mid_run");
      expectAt(1, e + 4, 4'd0, 1'b0, 1'b0, "rst_second");
      for (int k = 5; k < 15; k += 3) begin
         expectAt(1, e + k, 4'd0, 1'b0, 1'b0, "rst_after");
      end
      waitCycles(3);
      rst = 1'b1;
      waitCycles(2);
      rst = 1'b0;
      waitCycles(10);

      // Reset on the terminal-count edge suppresses done
      applyStimulus(1, 1'b1, 1'b0, 1'b0, 4'd1, e);
      expectAt(1, e + 1, 4'd0, 1'b1, 1'b0, "rstdone_q0");
      expectAt(1, e + 2, 4'd0, 1'b0, 1'b0, "rstdone_suppressed");
      expectAt(1, e + 3, 4'd0, 1'b0, 1'b0, "rstdone_after");
      waitCycles(2);
      rst = 1'b1;
      waitCycles(1);
      rst = 1'b0;
      waitCycles(4);
      #1;

      foreach (expQ[i]) begin
         checks++;
         errors++;
         $display("[TB] FAIL unchecked_%s dut%0d edge %0d: got no sample, want one", expQ[i].tag, expQ[i].dut, expQ[i].cyc);
      end
      foreach (doneQ1[i]) begin
         checks++;
         errors++;
         $display("[TB] FAIL missing_done dut1 edge %0d: got done=0, want done=1", doneQ1[i]);
      end
      foreach (doneQ4[i]) begin
         checks++;
         errors++;
         $display("[TB] FAIL missing_done dut4 edge %0d: got done=0, want done=1", doneQ4[i]);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
